micro_seq: RTL and testbench

MICRO_SEQ -- requirements
Module: micro_seq

---
 rtl/micro_seq_pkg.sv | 25 ++
 rtl/micro_prog_mem.sv | 30 +++
 rtl/micro_seq.sv | 100 ++++++++++
 tb/tb_micro_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/micro_seq_pkg.sv
// Shared encodings for the micro sequencer: opcode prefixes, fill words and FSM states.
package micro_seq_pkg;

   localparam logic [1:0] SEQ_CLASS = 2'b11;

   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_DJNZ = 4'hD;
   localparam logic [3:0] OP_LDC  = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   // No register load, OE[7] selects nobody: the datapath bus floats.
   localparam logic [7:0] NOP_WORD  = 8'hC7;
   localparam logic [7:0] HALT_FILL = 8'hF0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   function automatic logic is_seq_word(input logic [7:0] w);
      return (w[7:6] == SEQ_CLASS);
   endfunction

endpackage

// File: rtl/micro_prog_mem.sv
// Program store: 2**PC_W x 8 register file, reset-filled with HALT, one write port, async read.
module micro_prog_mem
   import micro_seq_pkg::*;
#(
   parameter int unsigned PC_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [PC_W-1:0] waddr,
   input  logic [7:0]      wdata,
   input  logic [PC_W-1:0] raddr,
   output logic [7:0]      rdata
);

   localparam int unsigned DEPTH = 1 << PC_W;

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         mem <= '{default: HALT_FILL};
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/micro_seq.sv
// Micro sequencer: fetches one word per cycle, forwards datapath words, executes JMP/DJNZ/LDC/HALT.
module micro_seq
   import micro_seq_pkg::*;
#(
   parameter int unsigned PC_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            prog_we,
   input  logic [PC_W-1:0] prog_addr,
   input  logic [7:0]      prog_wdata,
   input  logic            start,
   output logic [7:0]      inst,
   output logic            busy,
   output logic            done,
   output logic [PC_W-1:0] pc
);

   state_t          state;
   logic [3:0]      cnt;
   logic [3:0]      cnt_dec;
   logic [7:0]      word;
   logic [PC_W-1:0] target;
   logic [PC_W-1:0] pc_inc;
   logic            mem_we;

   // Program loads are only accepted while the sequencer is parked.
   assign mem_we  = prog_we && (state == ST_IDLE);
   assign cnt_dec = cnt - 4'd1;
   assign target  = PC_W'(word[3:0]);
   assign pc_inc  = pc + 1'b1;

   micro_prog_mem #(
      .PC_W (PC_W)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (mem_we),
      .waddr (prog_addr),
      .wdata (prog_wdata),
      .raddr (pc),
      .rdata (word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         pc    <= '0;
         cnt   <= '0;
         inst  <= NOP_WORD;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         inst <= NOP_WORD;
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_RUN;
                  pc    <= '0;
                  busy  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (!is_seq_word(word)) begin
                  inst <= word;
                  pc   <= pc_inc;
               end else begin
                  case (word[7:4])
                     OP_JMP: begin
                        pc <= target;
                     end
                     OP_DJNZ: begin
                        cnt <= cnt_dec;
                        pc  <= (cnt_dec != 4'd0) ? target : pc_inc;
                     end
                     OP_LDC: begin
                        cnt <= word[3:0];
                        pc  <= pc_inc;
                     end
                     default: begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  endcase
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_micro_seq.sv
// Directed bench for micro_seq: per-cycle expected inst/busy/done/pc queued, then checked on negedge.
module tb_micro_seq;
   import micro_seq_pkg::*;

   localparam int PC_W = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            prog_we;
   logic [PC_W-1:0] prog_addr;
   logic [7:0]      prog_wdata;
   logic            start;
   logic [7:0]      inst;
   logic            busy;
   logic            done;
   logic [PC_W-1:0] pc;

   micro_seq #(
      .PC_W (PC_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_wdata (prog_wdata),
      .start      (start),
      .inst       (inst),
      .busy       (busy),
      .done       (done),
      .pc         (pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] inst;
      logic       busy;
      logic       done;
      logic [3:0] pc;
   } exp_t;

   exp_t  sb[$];
   int    vectors     = 0;
   int    miscompares = 0;
   string tag         = "init";

   task automatic push(input logic [7:0] i, input logic b, input logic d, input logic [3:0] p);
      exp_t e;
      e.inst = i;
      e.busy = b;
      e.done = d;
      e.pc   = p;
      sb.push_back(e);
   endtask

   task automatic check_one(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp)
      else begin
         miscompares++;
         $error("FAIL %s.%s: observed %0h expected %0h", tag, name, got, exp);
      end
   endtask

   // Advance one clock and compare the post-edge outputs against the next queued expectation.
   task automatic step();
      exp_t e;
      @(negedge clk);
      if (sb.size() == 0) begin
         $display("FAIL %s.queue: observed empty expected entry", tag);
         $fatal(1, "scoreboard underflow");
      end
      e = sb.pop_front();
      check_one("inst", {24'd0, inst}, {24'd0, e.inst});
      check_one("busy", {31'd0, busy}, {31'd0, e.busy});
      check_one("done", {31'd0, done}, {31'd0, e.done});
      check_one("pc",   {28'd0, pc},   {28'd0, e.pc});
   endtask

   task automatic run_trace();
      while (sb.size() > 0) step();
   endtask

   task automatic write_word(input logic [3:0] a, input logic [7:0] d);
      prog_we    = 1'b1;
      prog_addr  = a;
      prog_wdata = d;
      @(negedge clk);
      prog_we    = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      push(8'hC7, 1'b0, 1'b0, 4'd0);
      step();
      rst = 1'b0;
   endtask

   task automatic run_prog();
      start = 1'b1;
      step();
      start = 1'b0;
      run_trace();
   endtask

   task automatic abort_run();
      rst = 1'b1;
      push(8'hC7, 1'b0, 1'b0, 4'd0);
      step();
      rst = 1'b0;
      check_one("state", {30'd0, dut.state}, {30'd0, ST_IDLE});
      push(8'hC7, 1'b0, 1'b0, 4'd0);
      push(8'hC7, 1'b0, 1'b0, 4'd0);
      run_trace();
   endtask

   initial begin
      rst        = 1'b1;
      prog_we    = 1'b0;
      prog_addr  = '0;
      prog_wdata = '0;
      start      = 1'b0;

      tag = "reset";
      do_reset();
      check_one("cnt", {28'd0, dut.cnt}, 32'd0);

      tag = "empty";
      push(8'hC7, 1'b1, 1'b0, 4'd0);
      push(8'hC7, 1'b0, 1'b1, 4'd0);
      push(8'hC7, 1'b0, 1'b0, 4'd0);
      run_prog();

      tag = "straight";
      write_word(4'd0, 8'h08);
      write_word(4'd1, 8'h50);
      write_word(4'd2, 8'hF0);
      push(8'hC7, 1'b1, 1'b0, 4'd0);
      push(8'h08, 1'b1, 1'b0, 4'd1);
      push(8'h50, 1'b1, 1'b0, 4'd2);
      push(8'hC7, 1'b0, 1'b1, 4'd2);
      push(8'hC7, 1'b0, 1'b0, 4'd2);
      run_prog();

      tag = "loop";
      do_reset();
      write_word(4'd0, 8'hE3);
      write_word(4'd1, 8'h48);
      write_word(4'd2, 8'hD1);
      write_word(4'd3, 8'hF0);
      push(8'hC7, 1'b1, 1'b0, 4'd0);
      push(8'hC7, 1'b1, 1'b0, 4'd1);
      push(8'h48, 1'b1, 1'b0, 4'd2);
      push(8'hC7, 1'b1, 1'b0, 4'd1);
      push(8'h48, 1'b1, 1'b0, 4'd2);
      push(8'hC7, 1'b1, 1'b0, 4'd1);
      push(8'h48, 1'b1, 1'b0, 4'd2);
      push(8'hC7, 1'b1, 1'b0, 4'd3);
      push(8'hC7, 1'b0, 1'b1, 4'd3);
      run_prog();
      check_one("cnt", {28'd0, dut.cnt}, 32'd0);
      push(8'hC7, 1'b0, 1'b0, 4'd3);
      run_trace();

      tag = "djnz_zero";
      do_reset();
      write_word(4'd0, 8'hD2);
      push(8'hC7, 1'b1, 1'b0, 4'd0);
      push(8'hC7, 1'b1, 1'b0, 4'd2);
      push(8'hC7, 1'b0, 1'b1, 4'd2);
      run_prog();
      check_one("cnt", {28'd0, dut.cnt}, 32'd15);
      push(8'hC7, 1'b0, 1'b0, 4'd2);
      run_trace();

      tag = "jmp_wrap";
      do_reset();
      for (int a = 0; a < 15; a++) write_word(4'(a), 8'h08);
      write_word(4'd15, 8'hC2);
      push(8'hC7, 1'b1, 1'b0, 4'd0);
      for (int k = 1; k <= 15; k++) push(8'h08, 1'b1, 1'b0, 4'(k));
      push(8'hC7, 1'b1, 1'b0, 4'd2);
      for (int p = 2; p <= 14; p++) push(8'h08, 1'b1, 1'b0, 4'(p + 1));
      push(8'hC7, 1'b1, 1'b0, 4'd2);
      run_prog();
      tag = "abort";
      abort_run();
      for (int i = 0; i < 16; i++) check_one("mem_fill", {24'd0, dut.u_mem.mem[i]}, 32'hF0);

      tag = "pc_wrap";
      write_word(4'd0, 8'hCE);
      write_word(4'd14, 8'h48);
      write_word(4'd15, 8'h50);
      push(8'hC7, 1'b1, 1'b0, 4'd0);
      push(8'hC7, 1'b1, 1'b0, 4'd14);
      push(8'h48, 1'b1, 1'b0, 4'd15);
      push(8'h50, 1'b1, 1'b0, 4'd0);
      push(8'hC7, 1'b1, 1'b0, 4'd14);
      run_prog();
      tag = "abort2";
      abort_run();

      tag = "we_start";
      prog_we    = 1'b1;
      prog_addr  = 4'd0;
      prog_wdata = 8'h50;
      start      = 1'b1;
      push(8'hC7, 1'b1, 1'b0, 4'd0);
      push(8'h50, 1'b1, 1'b0, 4'd1);
      push(8'hC7, 1'b0, 1'b1, 4'd1);
      push(8'hC7, 1'b0, 1'b0, 4'd1);
      step();
      prog_we = 1'b0;
      start   = 1'b0;
      run_trace();

      tag = "busy_ignore";
      do_reset();
      write_word(4'd0, 8'h08);
      push(8'hC7, 1'b1, 1'b0, 4'd0);
      push(8'h08, 1'b1, 1'b0, 4'd1);
      push(8'hC7, 1'b0, 1'b1, 4'd1);
      push(8'hC7, 1'b0, 1'b0, 4'd1);
      push(8'hC7, 1'b0, 1'b0, 4'd1);
      start = 1'b1;
      step();
      prog_we    = 1'b1;
      prog_addr  = 4'd0;
      prog_wdata = 8'h50;
      step();
      prog_we = 1'b0;
      start   = 1'b0;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      tag = "rerun";
      push(8'hC7, 1'b1, 1'b0, 4'd0);
      push(8'h08, 1'b1, 1'b0, 4'd1);
      push(8'hC7, 1'b0, 1'b1, 4'd1);
      push(8'hC7, 1'b0, 1'b0, 4'd1);
      run_prog();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
